// File: rtl/pipeline_step_controller.sv
// ---------------------------------------------------------------------------
// pipeline_step_controller
//   Execution sequencer for the 5-stage pipeline. Consumes command bytes from
//   the debug UART rx FIFO and drives the single enable that advances every
//   pipeline stage. Supports continuous run ('c'), single step ('s'),
//   run-N-cycles ('n' N), one PC breakpoint ('b' hi lo / 'r' clear), stop
//   from the host ('h') and stop on a halt opcode. Every stop is followed by
//   a state dump request; new commands wait until the dump has completed.
//
// Ports
//   clock, reset     : system clock, synchronous active-high reset
//   cmd_data/valid   : command byte and FIFO-not-empty from the UART rx FIFO
//   cmd_ready        : FIFO pop (byte consumed when cmd_valid & cmd_ready)
//   pc               : current IF-stage PC
//   instruccion      : instruction currently in IF/ID
//   pipeline_enable  : pipeline advances on edges where this is 1
//   halted           : 1 while idle and accepting commands
//   dump_request     : one-cycle pulse asking the debug unit to send state
//   dump_done        : debug unit finished transmission (one-cycle pulse)
//   cycle_count      : enabled cycles since reset (wraps)
//   state_debug      : encoded FSM state
// ---------------------------------------------------------------------------
module pipeline_step_controller #(
   parameter int         PC_WIDTH    = 11,
   parameter int         CNT_WIDTH   = 16,
   parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [7:0]           cmd_data,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic [31:0]          instruccion,
   output logic                 pipeline_enable,
   output logic                 halted,
   output logic                 dump_request,
   input  logic                 dump_done,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [2:0]           state_debug
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_STEP  = 3'd2;
   localparam logic [2:0] S_RUN_N = 3'd3;
   localparam logic [2:0] S_ARG1  = 3'd4;
   localparam logic [2:0] S_ARG2  = 3'd5;
   localparam logic [2:0] S_DUMP  = 3'd6;

   localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
   localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
   localparam logic [7:0] CMD_RUN_N = 8'h6E;  // 'n'
   localparam logic [7:0] CMD_BP    = 8'h62;  // 'b'
   localparam logic [7:0] CMD_CLRBP = 8'h72;  // 'r'
   localparam logic [7:0] CMD_HALT  = 8'h68;  // 'h'

   logic [2:0]           state_q, state_d;
   logic                 bp_valid_q, bp_valid_d;
   logic [PC_WIDTH-1:0]  bp_addr_q, bp_addr_d;
   logic [7:0]           run_cnt_q, run_cnt_d;
   logic                 skip_q, skip_d;
   logic [7:0]           arg_hi_q, arg_hi_d;
   logic                 arg_is_bp_q, arg_is_bp_d;
   logic                 dump_first_q, dump_first_d;
   logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;

   logic in_run;
   logic stop_hit;
   logic pop;
   logic halt_cmd;

   // Only the opcode field of the instruction matters here.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instruccion[25:0];

   // State register and all controller flops.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         bp_valid_q    <= 1'b0;
         bp_addr_q     <= '0;
         run_cnt_q     <= '0;
         skip_q        <= 1'b0;
         arg_hi_q      <= '0;
         arg_is_bp_q   <= 1'b0;
         dump_first_q  <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         bp_valid_q    <= bp_valid_d;
         bp_addr_q     <= bp_addr_d;
         run_cnt_q     <= run_cnt_d;
         skip_q        <= skip_d;
         arg_hi_q      <= arg_hi_d;
         arg_is_bp_q   <= arg_is_bp_d;
         dump_first_q  <= dump_first_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   // Outputs, decoded from the current state.
   always_comb begin
      in_run   = (state_q == S_RUN) || (state_q == S_RUN_N);
      // The first cycle after (re)entering a run is always executed so that
      // resuming from a breakpoint or halt opcode makes forward progress.
      stop_hit = in_run && !skip_q &&
                 ((bp_valid_q && (pc == bp_addr_q)) ||
                  (instruccion[31:26] == HALT_OPCODE));

      pipeline_enable = 1'b0;
      cmd_ready       = 1'b0;
      case (state_q)
         S_IDLE, S_ARG1, S_ARG2: cmd_ready = 1'b1;
         S_RUN, S_RUN_N: begin
            cmd_ready       = 1'b1;
            pipeline_enable = !stop_hit;
         end
         S_STEP:  pipeline_enable = 1'b1;
         default: ;
      endcase

      pop          = cmd_valid && cmd_ready;
      halt_cmd     = pop && (cmd_data == CMD_HALT);
      halted       = (state_q == S_IDLE);
      dump_request = dump_first_q;
      cycle_count  = cycle_count_q;
      state_debug  = state_q;
   end

   // Next-state and register update logic.
   always_comb begin
      state_d       = state_q;
      bp_valid_d    = bp_valid_q;
      bp_addr_d     = bp_addr_q;
      run_cnt_d     = run_cnt_q;
      arg_hi_d      = arg_hi_q;
      arg_is_bp_d   = arg_is_bp_q;
      cycle_count_d = pipeline_enable ? cycle_count_q + CNT_WIDTH'(1) : cycle_count_q;

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               case (cmd_data)
                  CMD_RUN:   state_d = S_RUN;
                  CMD_STEP:  state_d = S_STEP;
                  CMD_RUN_N: begin
                     state_d     = S_ARG1;
                     arg_is_bp_d = 1'b0;
                  end
                  CMD_BP: begin
                     state_d     = S_ARG1;
                     arg_is_bp_d = 1'b1;
                  end
                  CMD_CLRBP: bp_valid_d = 1'b0;
                  default:   ;
               endcase
            end
         end
         S_ARG1: begin
            if (pop) begin
               if (arg_is_bp_q) begin
                  arg_hi_d = cmd_data;
                  state_d  = S_ARG2;
               end else begin
                  run_cnt_d = cmd_data;
                  state_d   = (cmd_data == 8'd0) ? S_IDLE : S_RUN_N;
               end
            end
         end
         S_ARG2: begin
            if (pop) begin
               bp_addr_d  = PC_WIDTH'({arg_hi_q, cmd_data});
               bp_valid_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         S_RUN: begin
            if (stop_hit || halt_cmd) state_d = S_DUMP;
         end
         S_RUN_N: begin
            if (pipeline_enable) run_cnt_d = run_cnt_q - 8'd1;
            // Early stops discard whatever count is left.
            if (stop_hit || halt_cmd || (pipeline_enable && run_cnt_q == 8'd1)) begin
               state_d   = S_DUMP;
               run_cnt_d = '0;
            end
         end
         S_STEP: state_d = S_DUMP;
         S_DUMP: begin
            if (dump_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      skip_d       = ((state_d == S_RUN) || (state_d == S_RUN_N)) && !in_run;
      dump_first_d = (state_d == S_DUMP) && (state_q != S_DUMP);
   end

endmodule

// File: tb/tb_pipeline_step_controller.sv
module tb_pipeline_step_controller;
   localparam int PCW = 11;
   localparam int CW  = 16;

   localparam logic [7:0] C_RUN  = 8'h63;
   localparam logic [7:0] C_STEP = 8'h73;
   localparam logic [7:0] C_RUNN = 8'h6E;
   localparam logic [7:0] C_BP   = 8'h62;
   localparam logic [7:0] C_CLR  = 8'h72;
   localparam logic [7:0] C_HALT = 8'h68;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [7:0]     cmd_data = 8'h00;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [PCW-1:0] pc;
   logic [31:0]    instruccion = 32'h0;
   logic           pipeline_enable;
   logic           halted;
   logic           dump_request;
   logic           dump_done = 1'b0;
   logic [CW-1:0]  cycle_count;
   logic [2:0]     state_debug;

   int n_checks = 0;
   int n_err    = 0;
   int en_cnt   = 0;
   int dump_cnt = 0;
   int cur_run  = 0;
   int last_run = 0;
   int dd_delay = 4;
   int dd_timer = 0;
   int pc_raw   = 0;
   int pc_base  = 0;
   int exp_total = 0;

   pipeline_step_controller #(.PC_WIDTH(PCW), .CNT_WIDTH(CW), .HALT_OPCODE(6'b111111)) dut (
      .clock(clock), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .pc(pc), .instruccion(instruccion),
      .pipeline_enable(pipeline_enable), .halted(halted), .dump_request(dump_request),
      .dump_done(dump_done), .cycle_count(cycle_count), .state_debug(state_debug)
   );

   always #5 clock = ~clock;

   // PC model: advances by one on every enabled edge.
   always @(posedge clock) if (pipeline_enable === 1'b1) pc_raw <= pc_raw + 1;
   assign pc = PCW'(pc_raw - pc_base);

   // Activity monitor.
   always @(negedge clock) begin
      if (pipeline_enable === 1'b1) begin
         en_cnt  = en_cnt + 1;
         cur_run = cur_run + 1;
      end else if (cur_run > 0) begin
         last_run = cur_run;
         cur_run  = 0;
      end
      if (dump_request === 1'b1) dump_cnt = dump_cnt + 1;
   end

   // Debug-unit model: answers each dump_request with a dump_done pulse
   // dd_delay cycles later (0 = in the request cycle itself).
   always @(negedge clock) begin
      dump_done = 1'b0;
      if (dump_request === 1'b1) begin
         if (dd_delay == 0) dump_done = 1'b1;
         else dd_timer = dd_delay;
      end else if (dd_timer > 0) begin
         if (dd_timer == 1) dump_done = 1'b1;
         dd_timer = dd_timer - 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      assert (obs === req) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, req);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_checks++;
      n_err++;
      $error("FAIL %s: observed=timeout expected=event", tag);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      cmd_data  = b;
      cmd_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("cmd_ready_wait");
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clock);
         if (halted === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("idle_wait");
      @(posedge clock);
      #1;
   endtask

   initial begin
      int e0, d0, nlow, sel, n;
      bit ok;
      logic [7:0] b;

      // ---- reset state ----
      repeat (3) @(posedge clock);
      #1;
      check("rst_state", 32'(state_debug), 0);
      check("rst_halted", 32'(halted), 1);
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      check("rst_enable", 32'(pipeline_enable), 0);
      check("rst_dump_req", 32'(dump_request), 0);
      check("rst_cycle_count", 32'(cycle_count), 0);
      reset = 1'b0;

      // ---- three single steps ----
      e0 = en_cnt; d0 = dump_cnt; dd_delay = 4;
      repeat (3) begin
         send_byte(C_STEP);
         wait_idle(50);
      end
      check("step_enables", en_cnt - e0, 3);
      check("step_dumps", dump_cnt - d0, 3);
      check("step_cycle_count", 32'(cycle_count), 3);
      check("step_halted", 32'(halted), 1);
      exp_total = 3;

      // ---- run 5 cycles ----
      e0 = en_cnt; d0 = dump_cnt;
      send_byte(C_RUNN);
      send_byte(8'd5);
      wait_idle(50);
      check("runn5_enables", en_cnt - e0, 5);
      check("runn5_consecutive", last_run, 5);
      check("runn5_dumps", dump_cnt - d0, 1);
      exp_total += 5;
      check("runn5_cycle_count", 32'(cycle_count), 32'(exp_total));

      // ---- run 0 cycles ----
      e0 = en_cnt; d0 = dump_cnt;
      send_byte(C_RUNN);
      send_byte(8'd0);
      repeat (3) @(posedge clock);
      #1;
      check("runn0_enables", en_cnt - e0, 0);
      check("runn0_dumps", dump_cnt - d0, 0);
      check("runn0_state", 32'(state_debug), 0);

      // ---- breakpoint at 12 ----
      pc_base = pc_raw;
      send_byte(C_BP); send_byte(8'h00); send_byte(8'h0C);
      e0 = en_cnt; d0 = dump_cnt;
      send_byte(C_RUN);
      wait_idle(100);
      check("bp_pc", 32'(pc), 12);
      check("bp_enables", en_cnt - e0, 12);
      check("bp_dumps", dump_cnt - d0, 1);

      // ---- resume past the breakpoint, stop with 'h' ----
      e0 = en_cnt; d0 = dump_cnt;
      send_byte(C_RUN);
      repeat (5) @(posedge clock);
      #1;
      send_byte(C_HALT);
      wait_idle(50);
      check("resume_enables", en_cnt - e0, 6);
      check("resume_pc", 32'(pc), 18);
      check("resume_dumps", dump_cnt - d0, 1);
      send_byte(C_CLR);

      // ---- halt opcode ----
      d0 = dump_cnt;
      send_byte(C_RUN);
      repeat (3) @(posedge clock);
      #1;
      instruccion = 32'hFC00_0000;
      @(negedge clock);
      check("halt_op_enable", 32'(pipeline_enable), 0);
      check("halt_op_state_run", 32'(state_debug), 1);
      @(posedge clock);
      #1;
      instruccion = 32'h0;
      check("halt_op_state_dump", 32'(state_debug), 6);
      check("halt_op_dump_req", 32'(dump_request), 1);
      wait_idle(50);
      check("halt_op_dumps", dump_cnt - d0, 1);

      // ---- halt opcode and 'h' together ----
      d0 = dump_cnt;
      send_byte(C_RUN);
      repeat (3) @(posedge clock);
      #1;
      instruccion = 32'hFC00_0000;
      cmd_data = C_HALT;
      cmd_valid = 1'b1;
      @(negedge clock);
      check("halt_both_enable", 32'(pipeline_enable), 0);
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      instruccion = 32'h0;
      wait_idle(50);
      check("halt_both_dumps", dump_cnt - d0, 1);

      // ---- commands blocked during DUMP ----
      dd_delay = 10;
      send_byte(C_RUN);
      repeat (20) @(posedge clock);
      #1;
      send_byte(C_HALT);
      cmd_data = C_STEP;
      cmd_valid = 1'b1;
      nlow = 0; ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (state_debug === 3'd6) begin
            if (cmd_ready === 1'b0) nlow++;
         end else if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("dump_block_wait");
      check("dump_block_cycles", nlow, 11);
      e0 = en_cnt;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      wait_idle(50);
      check("dump_then_step", en_cnt - e0, 1);

      // ---- reset during RUN_N ----
      dd_delay = 4;
      send_byte(C_BP); send_byte(8'h00); send_byte(8'h02);
      pc_base = pc_raw - 300;
      send_byte(C_RUNN);
      send_byte(8'd200);
      repeat (50) @(posedge clock);
      #1;
      check("mid_runn_state", 32'(state_debug), 3);
      d0 = dump_cnt;
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("rst_runn_state", 32'(state_debug), 0);
      check("rst_runn_count", 32'(cycle_count), 0);
      check("rst_runn_dump_req", 32'(dump_request), 0);
      reset = 1'b0;
      exp_total = 0;
      repeat (4) @(posedge clock);
      #1;
      check("rst_runn_no_dump", dump_cnt - d0, 0);
      // breakpoint at 2 must be gone: run 4 cycles straight through pc 2
      pc_base = pc_raw;
      e0 = en_cnt;
      send_byte(C_RUNN);
      send_byte(8'd4);
      wait_idle(50);
      check("bp_cleared_enables", en_cnt - e0, 4);
      check("bp_cleared_pc", 32'(pc), 4);
      exp_total += 4;
      check("bp_cleared_count", 32'(cycle_count), 32'(exp_total));

      // ---- reset during DUMP ----
      dd_delay = 10;
      send_byte(C_STEP);
      @(posedge clock);
      #1;
      check("pre_rst_dump_state", 32'(state_debug), 6);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("rst_dump_state", 32'(state_debug), 0);
      check("rst_dump_count", 32'(cycle_count), 0);
      reset = 1'b0;
      exp_total = 0;
      d0 = dump_cnt; e0 = en_cnt;
      repeat (15) @(posedge clock);
      #1;
      check("rst_dump_stays_idle", 32'(state_debug), 0);
      check("rst_dump_quiet", (dump_cnt - d0) + (en_cnt - e0), 0);

      // ---- randomized command sequence vs reference model ----
      for (int it = 0; it < 12; it++) begin
         int want_en, want_dump;
         sel = $urandom_range(0, 3);
         dd_delay = $urandom_range(0, 5);
         e0 = en_cnt; d0 = dump_cnt;
         want_en = 0; want_dump = 0;
         case (sel)
            0: begin
               send_byte(C_STEP);
               want_en = 1; want_dump = 1;
            end
            1: begin
               n = $urandom_range(1, 20);
               send_byte(C_RUNN);
               send_byte(8'(n));
               want_en = n; want_dump = 1;
            end
            2: begin
               send_byte(C_RUNN);
               send_byte(8'd0);
            end
            default: begin
               b = 8'h41 + 8'($urandom_range(0, 5));
               send_byte(b);
            end
         endcase
         repeat (2) @(posedge clock);
         wait_idle(60);
         exp_total += want_en;
         check($sformatf("rand%0d_enables", it), en_cnt - e0, want_en);
         check($sformatf("rand%0d_dumps", it), dump_cnt - d0, want_dump);
      end
      check("rand_cycle_count", 32'(cycle_count), 32'(exp_total % 65536));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_step_controller.md
Name: pipeline_step_controller

Overview:
Execution sequencer for the 5-stage pipeline. It takes command bytes from the debug UART receive FIFO and generates the single enable that advances every pipeline stage. It supports continuous run, single step, run-N-cycles, one PC breakpoint and a halt-opcode stop. After every stop it issues a register/latch dump request to the UART debug unit and waits for completion before it accepts new commands.

Parameters:
PC_WIDTH, 11, width of the IF-stage PC and of the breakpoint register
CNT_WIDTH, 16, width of the free-running executed-cycle counter
HALT_OPCODE, 6'b111111, value of instruccion[31:26] that stops execution

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_data  in  8  command byte from the UART rx FIFO
cmd_valid  in  1  cmd_data valid (FIFO not empty)
cmd_ready  out  1  byte consumed this cycle when cmd_valid & cmd_ready (FIFO pop)
pc  in  PC_WIDTH  current IF-stage PC
instruccion  in  32  instruction currently in IF/ID
pipeline_enable  out  1  pipeline advances on clock edges where this is 1
halted  out  1  1 while in IDLE
dump_request  out  1  one-cycle pulse asking the debug unit to transmit state
dump_done  in  1  debug unit finished transmission (single-cycle pulse)
cycle_count  out  CNT_WIDTH  number of enabled cycles since reset
state_debug  out  3  encoded FSM state

Behaviour:
- Reset: state=IDLE. pipeline_enable=0, dump_request=0, cycle_count=0, breakpoint invalid, bp_addr=0, run counter=0, skip flag=0, arg registers=0. halted=1, cmd_ready=1.
- State encoding (state_debug): IDLE=0, RUN=1, STEP=2, RUN_N=3, ARG1=4, ARG2=5, DUMP=6.
- Commands are accepted in IDLE only; unknown bytes are popped and ignored:
  - 0x63 'c' -> RUN
  - 0x73 's' -> STEP
  - 0x6E 'n' -> ARG1; the next byte N loads the run counter. N!=0 -> RUN_N. N=0 -> IDLE, no cycle executed.
  - 0x62 'b' -> ARG1, then ARG2. The first arg byte is the high byte, the second is the low byte. bp_addr = {hi,lo}[PC_WIDTH-1:0], breakpoint valid, return to IDLE.
  - 0x72 'r' -> clear breakpoint valid, stay in IDLE.
- cmd_ready: 1 in IDLE, ARG1, ARG2, RUN, RUN_N; 0 in STEP and DUMP. In RUN and RUN_N, byte 0x68 'h' stops execution (-> DUMP); all other bytes are popped and discarded.
- pipeline_enable is combinational: 1 in STEP; 1 in RUN/RUN_N unless stop_hit; 0 otherwise.
- stop_hit = ~skip & ((bp_valid & pc==bp_addr) | instruccion[31:26]==HALT_OPCODE).
- stop_hit is evaluated only in RUN and RUN_N. The stopping cycle has enable=0, so the pipeline holds with pc==bp_addr. Next state is DUMP.
- skip is set on every entry to RUN or RUN_N and cleared after the first cycle. Resuming from a breakpoint or halt therefore executes at least one cycle before a stop can fire again.
- STEP: exactly one enabled cycle, then DUMP.
- RUN_N: the counter decrements on each enabled cycle. On the enabled cycle with counter==1 -> DUMP, so exactly N enabled cycles occur. A stop_hit or 'h' ends RUN_N early; the remaining count is discarded.
- Simultaneous stop_hit and 'h' in the same cycle: a single transition to DUMP with one dump pulse.
- DUMP: dump_request=1 on the first DUMP cycle only. Wait for dump_done, then -> IDLE. A dump_done arriving in the entry cycle is accepted. dump_done outside DUMP is ignored.
- cycle_count increments on every cycle with pipeline_enable=1 and wraps modulo 2^CNT_WIDTH.
- Reset asserted in any state, including mid-RUN_N or DUMP, returns to the reset values on the next edge. No dump pulse is issued.

Test Plan:
- Reset, send 's' three times, pulsing dump_done 4 cycles after each dump_request -> exactly 3 enabled cycles, 3 dump pulses, cycle_count=3, halted=1 at end.
- Send 'n', 0x05 -> exactly 5 consecutive enabled cycles, then one dump pulse. Send 'n', 0x00 -> no enable, no dump, state_debug=0.
- Send 'b', 0x00, 0x0C, then 'c', with the PC model incrementing by 1 per enabled cycle from 0 -> enable drops in the cycle pc==12, one dump pulse. Send 'c' again -> at least one enabled cycle, pc moves past 12.
- In RUN, drive instruccion[31:26]=6'b111111 -> same-cycle enable=0, DUMP entered. Repeat with 'h' arriving on that same cycle -> only one dump_request pulse.
- Send 'c', then 'h' after 20 cycles; during DUMP hold cmd_valid=1 with 's' -> cmd_ready=0 and no pop until dump_done, then 's' executes one step.
- Assert reset mid-RUN_N (N=200, after 50 cycles) and during DUMP -> next cycle state_debug=0, cycle_count=0, breakpoint cleared, no dump_request.
